// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage decode inputs and hazard control outputs of the hazard unit
//
// Purpose: bundles the per-instruction decode information presented in D and
// the stall / forwarding / HI-LO busy controls returned by the hazard unit.
// Ports (signals):
//   src_addr_D  5*NUM_SRC  source register numbers, port i at [5i+4:5i]
//   src_use_D   2*NUM_SRC  consuming stage per port: 0=D, 1=E, 2=M
//   dst_addr_D  5          destination register
//   dst_valid_D 1          instruction writes the register file
//   dst_rdy_D   2          stage producing the result: 1=E, 2=M
//   md_start_D  1          mult/div in D
//   md_is_div_D 1          qualifies md_start_D (1=div)
//   md_read_D   1          mfhi/mflo/mthi/mtlo in D
//   flush_E     1          squash the instruction entering E
//   stall       1          freeze PC and IF/ID, bubble into E
//   fwd_D/E/M   2*NUM_SRC  forwarding selects: 0=regfile, 1=EX/MEM, 2=MEM/WB
//   md_busy     1          HI/LO unit busy
// Modports: master drives decode info, slave is the hazard unit.

interface hazard_scoreboard_if #(
    parameter int NUM_SRC = 2
);
    logic [5*NUM_SRC-1:0] src_addr_D;
    logic [2*NUM_SRC-1:0] src_use_D;
    logic [4:0]           dst_addr_D;
    logic                 dst_valid_D;
    logic [1:0]           dst_rdy_D;
    logic                 md_start_D;
    logic                 md_is_div_D;
    logic                 md_read_D;
    logic                 flush_E;
    logic                 stall;
    logic [2*NUM_SRC-1:0] fwd_D;
    logic [2*NUM_SRC-1:0] fwd_E;
    logic [2*NUM_SRC-1:0] fwd_M;
    logic                 md_busy;

    modport master (
        output src_addr_D, src_use_D, dst_addr_D, dst_valid_D, dst_rdy_D,
        output md_start_D, md_is_div_D, md_read_D, flush_E,
        input  stall, fwd_D, fwd_E, fwd_M, md_busy
    );

    modport slave (
        input  src_addr_D, src_use_D, dst_addr_D, dst_valid_D, dst_rdy_D,
        input  md_start_D, md_is_div_D, md_read_D, flush_E,
        output stall, fwd_D, fwd_E, fwd_M, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall and forwarding control for the 5-stage pipeline
//
// Purpose: keeps a shadow copy (E/M/W) of the destination and source info of
// every in-flight instruction and derives from it the per-operand forwarding
// selects at D, E and M, the load-use / branch stall, and the HI/LO
// (mult/div) busy interlock.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   hz     hazard_scoreboard_if.slave: D-stage decode info in, controls out

module hazard_scoreboard #(
    parameter int NUM_SRC     = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   hz
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           dst;
        logic [1:0]           rdy;
        logic [5*NUM_SRC-1:0] src;
        logic [2*NUM_SRC-1:0] stage_use;
    } shadow_t;

    shadow_t          sh_E;
    shadow_t          sh_M;
    shadow_t          sh_W;
    shadow_t          d_entry;
    logic [CNT_W-1:0] md_cnt;

    logic                 dep_stall;
    logic                 md_stall;
    logic                 stall;
    logic                 md_busy;
    logic [2*NUM_SRC-1:0] fwd_d;
    logic [2*NUM_SRC-1:0] fwd_e;
    logic [2*NUM_SRC-1:0] fwd_m;

    logic [4:0] src_d;
    logic [4:0] src_e;
    logic [4:0] src_m;
    logic [2:0] use_d;

    // Shadow fields that no later decision looks at; folded here so the
    // full record can still travel down the pipe unchanged.
    logic unused_shadow_bits;
    assign unused_shadow_bits = ^{sh_E.stage_use, sh_M.stage_use,
                                  sh_W.rdy, sh_W.src, sh_W.stage_use};

    // A producer matches a source only when it really writes that register;
    // $0 is hard-wired and never creates a dependency.
    function automatic logic hit(input shadow_t s, input logic [4:0] r);
        return s.valid && (s.dst == r) && (r != 5'd0);
    endfunction

    always_comb begin
        d_entry           = '0;
        d_entry.valid     = hz.dst_valid_D;
        d_entry.dst       = hz.dst_addr_D;
        d_entry.rdy       = hz.dst_rdy_D;
        d_entry.src       = hz.src_addr_D;
        d_entry.stage_use = hz.src_use_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_E <= '0;
            sh_M <= '0;
            sh_W <= '0;
        end else begin
            sh_W <= sh_M;
            sh_M <= sh_E;
            sh_E <= (stall || hz.flush_E) ? '0 : d_entry;
        end
    end

    // Forwarding and dependency stall. For every operand the youngest matching
    // producer decides; an older match behind it is never consulted.
    always_comb begin
        fwd_d     = '0;
        fwd_e     = '0;
        fwd_m     = '0;
        dep_stall = 1'b0;
        src_d     = '0;
        src_e     = '0;
        src_m     = '0;
        use_d     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_d = hz.src_addr_D[5*i +: 5];
            src_e = sh_E.src[5*i +: 5];
            src_m = sh_M.src[5*i +: 5];
            use_d = {1'b0, hz.src_use_D[2*i +: 2]};

            // Operand in D. A producer still in E has nothing latched yet,
            // so the select stays at the regfile and the stall covers it.
            if (hit(sh_E, src_d)) begin
                fwd_d[2*i +: 2] = SEL_RF;
                if (use_d + 3'd1 <= {1'b0, sh_E.rdy})
                    dep_stall = 1'b1;
            end else if (hit(sh_M, src_d)) begin
                fwd_d[2*i +: 2] = (sh_M.rdy == 2'd1) ? SEL_MEM : SEL_RF;
                if (use_d + 3'd2 <= {1'b0, sh_M.rdy})
                    dep_stall = 1'b1;
            end else if (hit(sh_W, src_d)) begin
                // Regfile is written at the end of W with no bypass.
                fwd_d[2*i +: 2] = SEL_WB;
            end

            // Operand held in ID/EX.
            if (hit(sh_M, src_e))
                fwd_e[2*i +: 2] = (sh_M.rdy == 2'd1) ? SEL_MEM : SEL_RF;
            else if (hit(sh_W, src_e))
                fwd_e[2*i +: 2] = SEL_WB;

            // Operand held in EX/MEM (store data).
            if (hit(sh_W, src_m))
                fwd_m[2*i +: 2] = SEL_WB;
        end
    end

    assign md_busy  = (md_cnt != '0);
    assign md_stall = md_busy && (hz.md_start_D || hz.md_read_D);
    assign stall    = dep_stall || md_stall;

    // HI/LO countdown starts only when the mult/div actually enters E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (hz.md_start_D && !stall && !hz.flush_E) begin
            md_cnt <= hz.md_is_div_D ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign hz.stall   = stall;
    assign hz.md_busy = md_busy;
    assign hz.fwd_D   = fwd_d;
    assign hz.fwd_E   = fwd_e;
    assign hz.fwd_M   = fwd_m;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    hazard_scoreboard_if #(.NUM_SRC(2)) hz ();

    hazard_scoreboard #(
        .NUM_SRC(2),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] u0, input logic [1:0] u1,
                         input logic [4:0] dst, input logic dv, input logic [1:0] rdy);
        hz.src_addr_D  = {s1, s0};
        hz.src_use_D   = {u1, u0};
        hz.dst_addr_D  = dst;
        hz.dst_valid_D = dv;
        hz.dst_rdy_D   = rdy;
        hz.md_start_D  = 1'b0;
        hz.md_is_div_D = 1'b0;
        hz.md_read_D   = 1'b0;
        hz.flush_E     = 1'b0;
        #1;
    endtask

    task automatic nop();
        issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic md_op(input logic start, input logic is_div, input logic rd);
        nop();
        hz.md_start_D  = start;
        hz.md_is_div_D = is_div;
        hz.md_read_D   = rd;
        #1;
    endtask

    task automatic drain();
        nop();
        for (int k = 0; k < 3; k++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        nop();
        check_eq("rst_stall", hz.stall, 0);
        check_eq("rst_busy", hz.md_busy, 0);
        check_eq("rst_fwd_D", hz.fwd_D, 0);
        check_eq("rst_fwd_E", hz.fwd_E, 0);
        check_eq("rst_fwd_M", hz.fwd_M, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // 1: lw $8 ; add $9,$8,$8
        issue(5'd9, 5'd0, 2'd1, 2'd0, 5'd8, 1'b1, 2'd2);
        check_eq("t1_lw_nostall", hz.stall, 0);
        step();
        issue(5'd8, 5'd8, 2'd1, 2'd1, 5'd9, 1'b1, 2'd1);
        check_eq("t1_stall", hz.stall, 1);
        step();
        check_eq("t1_release", hz.stall, 0);
        step();
        nop();
        check_eq("t1_fwd_E", hz.fwd_E, 4'b1010);
        check_eq("t1_nostall", hz.stall, 0);
        drain();

        // 2a: add $8 ; beq $8,$0
        issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1);
        step();
        issue(5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check_eq("t2a_stall", hz.stall, 1);
        step();
        check_eq("t2a_release", hz.stall, 0);
        check_eq("t2a_fwd_D", hz.fwd_D, 4'b0001);
        step();
        drain();

        // 2b: lw $8 ; beq $8,$0 -> two stall cycles, then from W
        issue(5'd9, 5'd0, 2'd1, 2'd0, 5'd8, 1'b1, 2'd2);
        step();
        issue(5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check_eq("t2b_stall1", hz.stall, 1);
        step();
        check_eq("t2b_stall2", hz.stall, 1);
        step();
        check_eq("t2b_release", hz.stall, 0);
        check_eq("t2b_fwd_D", hz.fwd_D, 4'b0010);
        step();
        drain();

        // 3a: add $8 ; sw $8,0($29) back-to-back
        issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1);
        step();
        issue(5'd29, 5'd8, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
        check_eq("t3a_nostall", hz.stall, 0);
        step();
        nop();
        check_eq("t3a_fwd_E", hz.fwd_E, 4'b0100);
        step();
        check_eq("t3a_fwd_M", hz.fwd_M, 4'b1000);
        drain();

        // 3b: add $8 ; nop ; sw $8
        issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1);
        step();
        nop();
        step();
        issue(5'd29, 5'd8, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
        check_eq("t3b_fwd_D", hz.fwd_D, 4'b0100);
        step();
        nop();
        check_eq("t3b_fwd_E", hz.fwd_E, 4'b1000);
        step();
        check_eq("t3b_fwd_M", hz.fwd_M, 4'b0000);
        drain();

        // 3c: add $8 ; nop ; nop ; sw $8
        issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1);
        step();
        nop();
        step();
        step();
        issue(5'd29, 5'd8, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
        check_eq("t3c_fwd_D", hz.fwd_D, 4'b1000);
        step();
        nop();
        check_eq("t3c_fwd_E", hz.fwd_E, 4'b0000);
        step();
        check_eq("t3c_fwd_M", hz.fwd_M, 4'b0000);
        drain();

        // 4: jal ; addu $2,$31,$0
        issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd31, 1'b1, 2'd1);
        step();
        issue(5'd31, 5'd0, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1);
        check_eq("t4_nostall", hz.stall, 0);
        step();
        nop();
        check_eq("t4_fwd_E", hz.fwd_E, 4'b0001);
        drain();

        // 4b: write $0 ; beq $0,$0
        issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 1'b1, 2'd1);
        step();
        issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check_eq("t4b_stall", hz.stall, 0);
        check_eq("t4b_fwd_D", hz.fwd_D, 0);
        step();
        check_eq("t4b_fwd_D_m", hz.fwd_D, 0);
        step();
        check_eq("t4b_fwd_D_w", hz.fwd_D, 0);
        drain();

        // 5a: div ; mflo
        md_op(1'b1, 1'b1, 1'b0);
        check_eq("t5_div_nostall", hz.stall, 0);
        step();
        check_eq("t5_div_busy", hz.md_busy, 1);
        md_op(1'b0, 1'b0, 1'b1);
        n = 0;
        while (hz.stall && n < 40) begin
            n++;
            step();
        end
        check_eq("t5_div_hold", n, 10);
        check_eq("t5_div_idle", hz.md_busy, 0);
        step();
        drain();

        // 5b: mult ; mult
        md_op(1'b1, 1'b0, 1'b0);
        step();
        md_op(1'b1, 1'b0, 1'b0);
        n = 0;
        while (hz.stall && n < 40) begin
            n++;
            step();
        end
        check_eq("t5_mult_hold", n, 5);
        step();
        nop();
        check_eq("t5_mult2_busy", hz.md_busy, 1);
        n = 0;
        while (hz.md_busy && n < 40) begin
            n++;
            step();
        end
        check_eq("t5_mult2_len", n, 5);
        drain();

        // 6a: reset with md_cnt=4 and a load in E
        md_op(1'b1, 1'b1, 1'b0);
        step();
        nop();
        for (int k = 0; k < 5; k++) step();
        issue(5'd9, 5'd0, 2'd1, 2'd0, 5'd8, 1'b1, 2'd2);
        step();
        issue(5'd8, 5'd8, 2'd1, 2'd1, 5'd9, 1'b1, 2'd1);
        check_eq("t6_pre_stall", hz.stall, 1);
        check_eq("t6_pre_busy", hz.md_busy, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_stall", hz.stall, 0);
        check_eq("t6_rst_busy", hz.md_busy, 0);
        check_eq("t6_rst_fwd_D", hz.fwd_D, 0);
        check_eq("t6_rst_fwd_E", hz.fwd_E, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        drain();

        // 6b: flushed mult never loads the counter; flushed load never stalls
        md_op(1'b1, 1'b0, 1'b0);
        hz.flush_E = 1'b1;
        step();
        nop();
        check_eq("t6_flush_busy", hz.md_busy, 0);
        issue(5'd9, 5'd0, 2'd1, 2'd0, 5'd8, 1'b1, 2'd2);
        hz.flush_E = 1'b1;
        step();
        issue(5'd8, 5'd8, 2'd1, 2'd1, 5'd9, 1'b1, 2'd1);
        check_eq("t6_flush_bubble", hz.stall, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
